// File: rtl/dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared constants and the FSM state encoding for the data-memory arbiter.
//   Imported by the interface, the round-robin picker and the arbiter top.
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    // Default build configuration.
    localparam int DEF_NUM_REQ = 2;
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_DEPTH   = 32;

    // Idle cycles without an owner request before a lock is dropped.
    localparam int LOCK_TIMEOUT = 16;

    // Access FSM encoding, kept as plain constants so legacy tools can use it.
    typedef logic [1:0] state_t;
    localparam state_t IDLE   = 2'd0;
    localparam state_t ACCESS = 2'd1;
    localparam state_t DONE   = 2'd2;

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
//   Bundles the requester side and memory side of the data-memory arbiter.
//   Requester side : req, we, addr, wdata (flattened per requester),
//                    ack (one-hot), rdata, err.
//   Memory side    : mem_addr, mem_wr_enb, mem_wr_data, mem_val.
//   DMEM_ARB_LOCK_EN adds the per-requester lock input.
//   Modports: slave  - the arbiter
//             master - requesters plus memory (the environment)
// ---------------------------------------------------------------------------
interface dmem_arbiter_if
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) ();

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic                      err;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_wr_enb;
    logic [DATA_W-1:0]         mem_wr_data;
    logic [DATA_W-1:0]         mem_val;
`ifdef DMEM_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif

    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  lock,
`endif
        input  req, we, addr, wdata, mem_val,
        output ack, rdata, err, mem_addr, mem_wr_enb, mem_wr_data
    );

    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output lock,
`endif
        output req, we, addr, wdata, mem_val,
        input  ack, rdata, err, mem_addr, mem_wr_enb, mem_wr_data
    );

endinterface

// File: rtl/dmem_arbiter_rr_picker.sv
// ---------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selection. Scans the request vector starting
//   one past the last winner, wrapping modulo NUM_REQ; the first set bit wins.
//   Ports: i_req   - request vector
//          i_last  - index of the previous winner
//          o_grant - one-hot grant
//          o_idx   - index of the granted requester
//          o_any   - at least one request present
// ---------------------------------------------------------------------------
module rr_picker
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic [IDX_W-1:0] w_cand;

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_cand  = '0;
        // k == NUM_REQ revisits the last winner itself, so it only wins when
        // nobody else is asking.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_idx           = w_cand;
            end
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Round-robin arbiter sharing a single-port data memory between NUM_REQ
//   requesters. Each grant runs IDLE -> ACCESS -> DONE: operands are latched
//   at grant, the memory is driven for the single ACCESS cycle, and a one-hot
//   ack with rdata/err is presented for the DONE cycle.
//   Ports: clk, rst (async, active-high)
//          bus - dmem_arbiter_if.slave (requester and memory signals)
//   Optional: DMEM_ARB_LOCK_EN - a winner finishing with lock high keeps
//   exclusive ownership until it finishes an access with lock low, or until
//   LOCK_TIMEOUT consecutive idle cycles pass without an owner request.
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    state_t              r_state;
    logic [IDX_W-1:0]    r_last;      // previous winner, also current owner when locked
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [NUM_REQ-1:0]  r_ack;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   w_wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]  w_req_eff;
    logic [NUM_REQ-1:0]  w_grant;
    logic [IDX_W-1:0]    w_idx;
    logic                w_any;
    logic                w_in_range;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr_arr[g]  = bus.addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = bus.wdata[g*DATA_W +: DATA_W];
    end

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_TIMEOUT);

    logic             r_own_vld;
    logic [CNT_W-1:0] r_idle_cnt;

    // Ownership is decided from the winner's lock at the DONE exit; r_last
    // names the owner because only the owner can win while a lock is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_own_vld  <= 1'b0;
            r_idle_cnt <= '0;
        end else if (r_state == DONE) begin
            r_own_vld  <= bus.lock[r_last];
            r_idle_cnt <= '0;
        end else if (r_state == IDLE && r_own_vld && !bus.req[r_last]) begin
            if (r_idle_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                r_own_vld <= 1'b0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign w_req_eff = r_own_vld ? (bus.req & (NUM_REQ'(1) << r_last)) : bus.req;
`else
    assign w_req_eff = bus.req;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (w_req_eff),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Full-width unsigned compare so huge addresses never alias into range.
    assign w_in_range = (r_addr < ADDR_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state updates use non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (rst) begin
            r_state <= IDLE;
            r_last  <= IDX_W'(NUM_REQ - 1);
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_last  <= w_idx;
                        r_we    <= bus.we[w_idx];
                        r_addr  <= w_addr_arr[w_idx];
                        r_wdata <= w_wdata_arr[w_idx];
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rdata <= (w_in_range && !r_we) ? bus.mem_val : '0;
                    r_err   <= !w_in_range;
                    r_ack   <= r_grant;
                    r_state <= DONE;
                end
                DONE: begin
                    r_ack   <= '0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Address and write data come straight from the operand registers, so
    // they hold their last values outside ACCESS; only the enable is gated.
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wr_data = r_wdata;
    assign bus.mem_wr_enb  = (r_state == ACCESS) && r_we && w_in_range;

    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;
    assign bus.err   = r_err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//   Randomised bench for dmem_arbiter with a transaction-level reference:
//   requests are arbitrated by slot counting and round-robin arithmetic,
//   memory effects come from a plain array, and expected acks are queued for
//   a negedge monitor. Directed reset-mid-access checks run first.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int NUM_REQ = 3;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int DEPTH   = 32;
    localparam int MAW     = $clog2(DEPTH);

    typedef struct {
        int                who;
        logic [DATA_W-1:0] rdata;
        logic              err;
        int                cyc;
    } exp_t;

    typedef struct {
        bit                we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                lk;
        bit                drop;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Data memory: combinational read, write at the clock edge.
    logic [DATA_W-1:0] tb_mem [DEPTH];
    assign bus.mem_val = (bus.mem_addr < DEPTH) ? tb_mem[bus.mem_addr[MAW-1:0]] : 32'hBAD0_F00D;
    always @(posedge clk)
        if (bus.mem_wr_enb && bus.mem_addr < DEPTH)
            tb_mem[bus.mem_addr[MAW-1:0]] <= bus.mem_wr_data;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;
    exp_t sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per ack and checks every write address.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (bus.mem_wr_enb)
                check("wr_in_range", 64'(bus.mem_addr < DEPTH), 64'd1);
            if (bus.ack != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 64'(bus.ack), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("ack_vec", 64'(bus.ack), 64'd1 << e.who);
                    check("rdata", 64'(bus.rdata), 64'(e.rdata));
                    check("err", 64'(bus.err), 64'(e.err));
                    check("ack_cycle", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [DEPTH];
    txn_t cur [NUM_REQ];
    bit   pend [NUM_REQ];
    int   hold [NUM_REQ];
    int   busy, last, own, own_idle;
    bit   own_vld;
    txn_t dq0[$], dq1[$];

    task automatic issue(input int i, input txn_t t);
        cur[i]  = t;
        pend[i] = 1'b1;
        bus.req[i] = 1'b1;
        bus.we[i]  = t.we;
        bus.addr[i*ADDR_W +: ADDR_W]  = t.addr;
        bus.wdata[i*DATA_W +: DATA_W] = t.data;
`ifdef DMEM_ARB_LOCK_EN
        bus.lock[i] = t.lk;
`endif
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        int   r;
        t.we = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        if (r == 0)      t.addr = 32'($urandom_range(DEPTH, DEPTH + 15));
        else if (r == 1) t.addr = 32'h8000_0003;
        else if (r < 6)  t.addr = 32'($urandom_range(0, 7));
        else             t.addr = 32'($urandom_range(0, DEPTH - 1));
        t.data = $urandom;
`ifdef DMEM_ARB_LOCK_EN
        t.lk = ($urandom_range(0, 3) == 0);
`else
        t.lk = 1'b0;
`endif
        t.drop = ($urandom_range(0, 4) == 0);
        return t;
    endfunction

    // One cycle of the reference: runs at the negedge before the next edge.
    task automatic step(input bit gen);
        bit   finished;
        int   w;
        txn_t t;
        @(negedge clk);
        finished = (busy == 1);
        if (busy > 0) busy--;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (hold[i] > 0) begin
                hold[i]--;
                if (hold[i] == 2 && cur[i].drop) bus.req[i] = 1'b0;
                if (hold[i] == 0) begin
                    pend[i] = 1'b0;
                    bus.req[i] = 1'b0;
`ifdef DMEM_ARB_LOCK_EN
                    bus.lock[i] = 1'b0;
`endif
                end
            end
        end
        // An access just completed: its lock flag decides ownership.
        if (finished) begin
            own_vld  = cur[last].lk;
            own      = last;
            own_idle = 0;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!pend[i] && hold[i] == 0) begin
                if (i == 0 && dq0.size() > 0) issue(i, dq0.pop_front());
                else if (i == 1 && dq1.size() > 0) issue(i, dq1.pop_front());
                else if (gen && $urandom_range(0, 9) < 7) issue(i, rand_txn());
            end
        end
        if (busy == 0) begin
            w = -1;
            if (own_vld) begin
                if (pend[own]) w = own;
                else begin
                    own_idle++;
                    if (own_idle == LOCK_TIMEOUT) own_vld = 1'b0;
                end
            end else begin
                for (int k = 1; k <= NUM_REQ; k++)
                    if (w < 0 && pend[(last + k) % NUM_REQ]) w = (last + k) % NUM_REQ;
            end
            if (w >= 0) begin
                exp_t e;
                t = cur[w];
                e.who = w;
                e.cyc = cyc + 2;
                e.err = 1'b0;
                e.rdata = '0;
                if (t.addr < DEPTH) begin
                    if (t.we) ref_mem[t.addr[MAW-1:0]] = t.data;
                    else      e.rdata = ref_mem[t.addr[MAW-1:0]];
                end else begin
                    e.err = 1'b1;
                end
                sb_q.push_back(e);
                last    = w;
                busy    = 3;
                hold[w] = 3;
            end
        end
    endtask

    initial begin
        int guard;
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
`ifdef DMEM_ARB_LOCK_EN
        bus.lock = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            tb_mem[i]  = $urandom;
            ref_mem[i] = tb_mem[i];
        end

        // Reset state.
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        check("rst_mem_wr_data", 64'(bus.mem_wr_data), 64'd0);
        check("rst_mem_wr_enb", 64'(bus.mem_wr_enb), 64'd0);
        rst = 1'b0;

        // Reset in the middle of a write to word 3.
        @(negedge clk);
        bus.req[0] = 1'b1; bus.we[0] = 1'b1;
        bus.addr[0 +: ADDR_W] = 32'd3; bus.wdata[0 +: DATA_W] = 32'hA5;
        @(posedge clk);
        @(negedge clk);
        check("access_wr_enb", 64'(bus.mem_wr_enb), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_wr_enb", 64'(bus.mem_wr_enb), 64'd0);
        check("midrst_ack", 64'(bus.ack), 64'd0);
        check("midrst_mem_addr", 64'(bus.mem_addr), 64'd0);
        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
        @(negedge clk);
        check("midrst_word3", 64'(tb_mem[3]), 64'(ref_mem[3]));
        check("midrst_ack_after", 64'(bus.ack), 64'd0);
        rst = 1'b0;

        // Scoreboard phase: directed openers, then random traffic.
        busy = 0; last = NUM_REQ - 1; own = 0; own_idle = 0; own_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin pend[i] = 1'b0; hold[i] = 0; end
        dq0.push_back('{we: 1'b1, addr: 32'd4,  data: 32'hDEAD_BEEF, lk: 1'b0, drop: 1'b0});
        dq0.push_back('{we: 1'b0, addr: 32'd4,  data: 32'h0,         lk: 1'b0, drop: 1'b0});
        dq1.push_back('{we: 1'b0, addr: 32'd40, data: 32'h0,         lk: 1'b0, drop: 1'b0});
        dq1.push_back('{we: 1'b1, addr: 32'd40, data: 32'h1234_5678, lk: 1'b0, drop: 1'b0});
        dq1.push_back('{we: 1'b0, addr: 32'd4,  data: 32'h0,         lk: 1'b0, drop: 1'b1});
`ifdef DMEM_ARB_LOCK_EN
        dq0.push_back('{we: 1'b0, addr: 32'd2,  data: 32'h0,         lk: 1'b1, drop: 1'b0});
        dq0.push_back('{we: 1'b1, addr: 32'd2,  data: 32'h5555_AAAA, lk: 1'b0, drop: 1'b0});
        dq1.push_back('{we: 1'b0, addr: 32'd2,  data: 32'h0,         lk: 1'b0, drop: 1'b0});
`endif
        mon_en = 1'b1;
        repeat (3000) step(1'b1);

        // Drain outstanding work with a bounded wait.
        guard = 0;
        while ((sb_q.size() != 0 || busy != 0) && guard < 200) begin
            step(1'b0);
            guard++;
        end
        repeat (4) step(1'b0);
        check("drain_done", 64'(sb_q.size()), 64'd0);
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("mem[%0d]", i), 64'(tb_mem[i]), 64'(ref_mem[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
